// File: rtl/nibble_serial_adder.sv
// ---------------------------------------------------------------------------
// Module  : nibble_serial_adder (+ binaryadder_4bit)
// Brief   : Adds two W-bit operands one nibble per cycle through a 4-bit adder.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module binaryadder_4bit (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       c_in,
   output logic [3:0] s,
   output logic       c_out
);
   assign {c_out, s} = 5'(a) + 5'(b) + 5'(c_in);
endmodule

module nibble_serial_adder #(
   parameter int NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [4*NIBBLES-1:0] in_a,
   input  logic [4*NIBBLES-1:0] in_b,
   input  logic                 in_cin,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [4*NIBBLES-1:0] out_sum,
   output logic                 out_cout,
   output logic                 busy
);
   localparam int W     = 4 * NIBBLES;
   localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(NIBBLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADD  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [W-1:0]     r_a;
   logic [W-1:0]     r_b;
   logic [W-1:0]     r_sum;
   logic             r_carry;
   logic [IDX_W-1:0] r_idx;
   logic [3:0]       w_a_nib;
   logic [3:0]       w_b_nib;
   logic [3:0]       w_s;
   logic             w_cout;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (in_valid)                w_state_next = ST_ADD;
         ST_ADD:  if (r_idx == C_IDX_LAST)     w_state_next = ST_DONE;
         ST_DONE: if (out_ready)               w_state_next = ST_IDLE;
         default:                              w_state_next = ST_IDLE;
      endcase
   end

   // Select the current nibble of each operand.
   always_comb begin
      w_a_nib = '0;
      w_b_nib = '0;
      for (int n = 0; n < NIBBLES; n++) begin
         if (r_idx == IDX_W'(n)) begin
            w_a_nib = r_a[4*n +: 4];
            w_b_nib = r_b[4*n +: 4];
         end
      end
   end

   binaryadder_4bit u_adder (
      .a     (w_a_nib),
      .b     (w_b_nib),
      .c_in  (r_carry),
      .s     (w_s),
      .c_out (w_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_idx   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_a     <= in_a;
                  r_b     <= in_b;
                  r_carry <= in_cin;
                  r_idx   <= '0;
               end
            end
            ST_ADD: begin
               r_carry <= w_cout;
               for (int n = 0; n < NIBBLES; n++) begin
                  if (r_idx == IDX_W'(n)) begin
                     r_sum[4*n +: 4] <= w_s;
                  end
               end
               if (r_idx != C_IDX_LAST) begin
                  r_idx <= r_idx + IDX_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Result registers hold still in DONE, so backpressure needs no extra capture.
   assign in_ready  = (r_state == ST_IDLE);
   assign busy      = (r_state != ST_IDLE);
   assign out_valid = (r_state == ST_DONE);
   assign out_sum   = r_sum;
   assign out_cout  = r_carry;

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
// ---------------------------------------------------------------------------
// Module  : tb_nibble_serial_adder
// Brief   : Scoreboard bench: directed and random operand pairs vs. arithmetic model.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_nibble_serial_adder;
   localparam int NIBBLES = 4;
   localparam int W       = 4 * NIBBLES;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      int           t_acc;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         in_cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_sum;
   logic         out_cout;
   logic         busy;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   bit   rand_rdy = 0;

   nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: plain wide arithmetic.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      exp_t e;
      logic [W:0] full;
      full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
      e.sum  = full[W-1:0];
      e.cout = full[W];
      e.t_acc = 0;
      return e;
   endfunction

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      exp_t e;
      bit   ok = 0;
      in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1; break; end
      end
      if (!ok) begin
         chk("accept_timeout", 0, 1);
      end else begin
         e = model(a, b, c);
         e.t_acc = cyc + 1;
         sb.push_back(e);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int k = 0;
      while ((sb.size() != 0 || busy) && k < 500) begin
         @(posedge clk); #1;
         k++;
      end
      chk("drain_timeout", (k < 500) ? 1 : 0, 1);
   endtask

   // Monitor: pops on every handshake, checks latency and hold stability.
   bit           prev_valid = 0;
   bit           prev_hold  = 0;
   logic [W-1:0] held_sum;
   logic         held_cout;
   exp_t         got;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_valid = 0;
         prev_hold  = 0;
      end else begin
         if (out_valid && !prev_valid) begin
            if (sb.size() == 0) chk("unexpected_valid", 1, 0);
            else chk("latency", 64'(cyc - sb[0].t_acc), 64'(NIBBLES));
         end
         if (prev_hold) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_sum", out_sum, held_sum);
            chk("hold_cout", out_cout, held_cout);
         end
         if (out_valid) chk("in_ready_while_done", in_ready, 0);
         if (out_valid && out_ready && sb.size() != 0) begin
            got = sb.pop_front();
            chk("sum", out_sum, got.sum);
            chk("cout", out_cout, got.cout);
         end
         prev_hold  = out_valid && !out_ready;
         held_sum   = out_sum;
         held_cout  = out_cout;
         prev_valid = out_valid;
      end
   end

   always @(posedge clk) begin
      #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
   end

   initial begin
      int k;
      rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_sum", out_sum, 0);
      chk("rst_out_cout", out_cout, 0);
      chk("rst_busy", busy, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_in_ready", in_ready, 1);

      // Directed sums
      send(16'h1234, 16'h0FFF, 1'b0); drain();
      send(16'hFFFF, 16'h0001, 1'b0); drain();
      send(16'hFFFF, 16'hFFFF, 1'b1); drain();

      // Backpressure for 5 cycles in DONE
      out_ready = 1'b0;
      send(16'hA5A5, 16'h5A5B, 1'b1);
      k = 0;
      while (!out_valid && k < 50) begin @(posedge clk); #1; k++; end
      chk("bp_valid_seen", out_valid, 1);
      repeat (5) begin
         @(posedge clk); #1;
         chk("bp_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      drain();

      // Pair offered while busy must wait for IDLE
      send(16'h4321, 16'h1111, 1'b0);
      send(16'h0001, 16'h0001, 1'b0);
      drain();

      // Abort two cycles into ADD
      send(16'h7777, 16'h1111, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("abort_out_valid", out_valid, 0);
      chk("abort_busy", busy, 0);
      sb.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("abort_in_ready", in_ready, 1);
      chk("abort_out_sum", out_sum, 0);
      send(16'h00FF, 16'h0001, 1'b0); drain();

      // Random traffic with random backpressure
      rand_rdy = 1;
      for (int i = 0; i < 40; i++) begin
         send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
      end
      rand_rdy = 0;
      @(posedge clk); #1;
      out_ready = 1'b1;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got stuck expected finish");
      $fatal(1, "timeout");
   end
endmodule

`default_nettype wire
